// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg: shared widths, FSM encoding and helpers for the
// write-back port arbiter (wb_port_arbiter, wb_rr_pick).
package wb_port_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int STALL_W    = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB0  = 2'd1,
        WB1  = 2'd2
    } wb_state_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_req_t;

    function automatic logic [STALL_W-1:0] sat_inc(
        input logic [STALL_W-1:0] c
    );
        return (&c) ? c : c + STALL_W'(1);
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// wb_rr_pick: two-port grant selection. Ports: valid0/valid1 requests,
// last_grant pointer in; one-hot gnt0/gnt1 out. Macro WB_ARB_RR_EN.
module wb_rr_pick (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic gnt0,
    output logic gnt1
);

`ifndef WB_ARB_RR_EN
    // Fixed priority ignores the pointer; keep it visibly consumed.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case ({valid1, valid0})
            2'b01: gnt0 = 1'b1;
            2'b10: gnt1 = 1'b1;
            2'b11: begin
`ifdef WB_ARB_RR_EN
                // The port that did not win last time goes first.
                gnt0 = last_grant;
                gnt1 = ~last_grant;
`else
                // Mul/div results are rarer and longer-lived: favour them.
                gnt1 = 1'b1;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: merges ALU (port 0) and mul/div (port 1) write-backs
// onto one registered RF write port. Ports: clk, reset (sync, active-high),
// reqN_valid/addr/data in, reqN_ready out, rf_we/rf_waddr/rf_wdata out,
// stall_cnt (saturating refused-cycle count). Macro WB_ARB_RR_EN selects
// round-robin instead of fixed port-1 priority.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic [REG_ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0]     req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [REG_ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0]     req1_data,
    output logic                  req1_ready,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic [STALL_W-1:0]    stall_cnt
);

    wb_state_t             state_q;
    wb_state_t             state_d;
    logic                  last_grant_q;
    logic [REG_ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [STALL_W-1:0]    stall_q;

    logic    gnt0;
    logic    gnt1;
    logic    xfer0;
    logic    xfer1;
    logic    stall;
    wb_req_t sel;

    wb_rr_pick u_pick (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant_q),
        .gnt0       (gnt0),
        .gnt1       (gnt1)
    );

    // No handshake completes while reset is held.
    assign req0_ready = gnt0 & ~reset;
    assign req1_ready = gnt1 & ~reset;

    assign xfer0 = req0_valid & req0_ready;
    assign xfer1 = req1_valid & req1_ready;

    assign stall = (req0_valid & ~req0_ready)
                 | (req1_valid & ~req1_ready);

    always_comb begin
        sel = '0;
        unique case (1'b1)
            xfer1:   sel = '{addr: req1_addr, data: req1_data};
            xfer0:   sel = '{addr: req0_addr, data: req0_data};
            default: ;
        endcase
    end

    always_comb begin
        state_d = IDLE;
        unique case (1'b1)
            xfer0:   state_d = WB0;
            xfer1:   state_d = WB1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            waddr_q      <= '0;
            wdata_q      <= '0;
            stall_q      <= '0;
        end else begin
            state_q <= state_d;
            if (xfer0 | xfer1) begin
                last_grant_q <= xfer1;
                waddr_q      <= sel.addr;
                wdata_q      <= sel.data;
            end
            if (stall) begin
                stall_q <= sat_inc(stall_q);
            end
        end
    end

    // x0 is hard-wired zero: a write to it is accepted but never enabled.
    assign rf_we     = (state_q != IDLE) && (waddr_q != '0);
    assign rf_waddr  = waddr_q;
    assign rf_wdata  = wdata_q;
    assign stall_cnt = stall_q;

endmodule
